// File: rtl/lt24_timer_pkg.sv
// lt24_timer_pkg: interval-timer register map, control bits, driver FSM states and bus request type
package lt24_timer_pkg;
    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;
    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;
    typedef enum logic [3:0] {
        IDLE, W_STOP, W_PERL, W_PERH, W_CLR, W_CTRL, RUN,
        IRQ_CLR, S_WR, S_RDL, S_RDH, S_CAP, HALT
    } state_t;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [2:0]  addr;
        logic [15:0] data;
    } avm_req_t;
    function automatic avm_req_t wr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, 1'b1, a, d};
    endfunction
    function automatic avm_req_t rd(input logic [2:0] a);
        return {1'b1, 1'b0, a, 16'h0000};
    endfunction
endpackage

// File: rtl/lt24_timer_driver_if.sv
// lt24_timer_driver_if: Avalon-MM link between the driver (master) and the interval-timer s1 port (slave)
interface lt24_timer_driver_if #(parameter int ADDR_W = 3, parameter int DATA_W = 16);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              irq;
    modport master(output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave(input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/lt24_timer_driver_avm_access.sv
// lt24_avm_access: registers at most one Avalon-MM access per cycle; bus idles at cs=0, write_n=1, zeros
module lt24_avm_access
    import lt24_timer_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  avm_req_t req,
    lt24_timer_driver_if.master avm
);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            avm.chipselect <= 1'b0;
            avm.write_n    <= 1'b1;
            avm.address    <= '0;
            avm.writedata  <= '0;
        end else begin
            avm.chipselect <= req.valid;
            avm.write_n    <= !(req.valid && req.write);
            avm.address    <= req.valid ? req.addr : '0;
            avm.writedata  <= req.valid && req.write ? req.data : '0;
        end
endmodule

// File: rtl/lt24_timer_driver.sv
// lt24_timer_driver: programs, services and snapshots the interval timer, giving the painter a hardware tick
module lt24_timer_driver
    import lt24_timer_pkg::*;
#(
    parameter int TICK_CNT_W = 16,
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_start,
    input  logic [31:0]           cfg_period,
    input  logic                  cfg_continuous,
    input  logic                  cfg_stop,
    input  logic                  snap_req,
    output logic                  busy,
    output logic                  running,
    output logic                  tick,
    output logic [TICK_CNT_W-1:0] tick_count,
    output logic                  snap_valid,
    output logic [31:0]           snap_value,
    lt24_timer_driver_if.master   avm
);
    if (ADDR_W != 3 || DATA_W != 16) begin : g_bad_width
        $error("lt24_timer_driver supports only ADDR_W=3 and DATA_W=16");
    end
    state_t      state, nxt;
    logic [31:0] per_q;
    logic        cont_q, stop_pend, snap_pend;
    avm_req_t    req;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = cfg_start ? W_STOP : IDLE;
            W_STOP:  nxt = W_PERL;
            W_PERL:  nxt = W_PERH;
            W_PERH:  nxt = W_CLR;
            W_CLR:   nxt = W_CTRL;
            W_CTRL:  nxt = RUN;
            RUN:     nxt = avm.irq ? IRQ_CLR : stop_pend ? HALT : snap_pend ? S_WR : RUN;
            IRQ_CLR: nxt = cont_q ? RUN : IDLE;
            S_WR:    nxt = S_RDL;
            S_RDL:   nxt = S_RDH;
            S_RDH:   nxt = S_CAP;
            S_CAP:   nxt = RUN;
            default: nxt = IDLE;
        endcase
    end
    // The access is keyed on the state being entered so the bus cycle lines up with that state.
    always_comb begin
        req = '0;
        case (nxt)
            W_STOP, HALT:   req = wr(ADDR_CONTROL, 16'(1) << STOP);
            W_PERL:         req = wr(ADDR_PERIODL, per_q[15:0]);
            W_PERH:         req = wr(ADDR_PERIODH, per_q[31:16]);
            W_CLR, IRQ_CLR: req = wr(ADDR_STATUS, 16'h0000);
            W_CTRL:         req = wr(ADDR_CONTROL, 16'(1) << ITO | 16'(1) << START | 16'(cont_q) << CONT);
            S_WR:           req = wr(ADDR_SNAPL, 16'h0000);
            S_RDL:          req = rd(ADDR_SNAPL);
            S_RDH:          req = rd(ADDR_SNAPH);
            default:        req = '0;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state      <= IDLE;
            per_q      <= '0;
            cont_q     <= 1'b0;
            stop_pend  <= 1'b0;
            snap_pend  <= 1'b0;
            busy       <= 1'b0;
            running    <= 1'b0;
            tick       <= 1'b0;
            tick_count <= '0;
            snap_valid <= 1'b0;
            snap_value <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && cfg_start) begin
                per_q  <= cfg_period;
                cont_q <= cfg_continuous;
            end
            stop_pend  <= nxt == IDLE ? 1'b0 : state != IDLE && cfg_stop ? 1'b1 : nxt == HALT ? 1'b0 : stop_pend;
            snap_pend  <= nxt == IDLE ? 1'b0 : state != IDLE && snap_req ? 1'b1 : nxt == S_WR ? 1'b0 : snap_pend;
            busy       <= !(nxt inside {IDLE, RUN});
            running    <= nxt == RUN ? 1'b1 : nxt == IDLE ? 1'b0 : running;
            tick       <= nxt == IRQ_CLR;
            if (nxt == IRQ_CLR)
                tick_count <= tick_count + 1'b1;
            if (state == S_RDH)
                snap_value[15:0] <= avm.readdata;
            if (state == S_CAP)
                snap_value[31:16] <= avm.readdata;
            snap_valid <= state == S_CAP;
        end
    lt24_avm_access u_access (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .avm     (avm)
    );
endmodule

// File: tb/tb_lt24_timer_driver.sv
// tb_lt24_timer_driver: randomized scenarios against a cycle model of the interval timer,
// with expected timings and values derived arithmetically from the start cycle and period.
module tb_lt24_timer_driver;
    localparam int TW = 4;
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_start = 1'b0, cfg_continuous = 1'b0, cfg_stop = 1'b0, snap_req = 1'b0;
    logic [31:0]   cfg_period = '0;
    logic          busy, running, tick, snap_valid;
    logic [TW-1:0] tick_count;
    logic [31:0]   snap_value;
    int total = 0, bad = 0, cyc = 0, exp_ticks = 0;

    lt24_timer_driver_if avm ();

    lt24_timer_driver #(.TICK_CNT_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_period(cfg_period),
        .cfg_continuous(cfg_continuous), .cfg_stop(cfg_stop), .snap_req(snap_req),
        .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
        .snap_valid(snap_valid), .snap_value(snap_value), .avm(avm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Interval-timer model: counts period..0, sets TO at 0 and reloads; one-shot stops after TO.
    logic [31:0] t_period = '0, t_cnt = '0, t_snap = '0;
    logic        t_run = 1'b0, t_to = 1'b0, t_ito = 1'b0, t_cont = 1'b0;
    logic [15:0] t_rd = '0;
    assign avm.readdata = t_rd;
    assign avm.irq = t_to & t_ito;
    always @(posedge clk) begin
        t_rd <= !(avm.chipselect && avm.write_n) ? 16'h0 : avm.address == 3'd4 ? t_snap[15:0] :
                avm.address == 3'd5 ? t_snap[31:16] : 16'h0;
        if (t_run) begin
            if (t_cnt == 0) begin
                t_to  <= 1'b1;
                t_cnt <= t_period;
                if (!t_cont) t_run <= 1'b0;
            end else t_cnt <= t_cnt - 1;
        end
        if (avm.chipselect && !avm.write_n)
            case (avm.address)
                3'd0: t_to <= 1'b0;
                3'd1: begin
                    t_ito  <= avm.writedata[0];
                    t_cont <= avm.writedata[1];
                    if (avm.writedata[3]) t_run <= 1'b0;
                    else if (avm.writedata[2]) begin
                        t_run <= 1'b1;
                        t_cnt <= t_period;
                    end
                end
                3'd2: t_period[15:0] <= avm.writedata;
                3'd3: t_period[31:16] <= avm.writedata;
                3'd4: t_snap <= t_cnt;
                default: ;
            endcase
    end

    typedef struct packed {int c; logic w; logic [2:0] a; logic [15:0] d;} acc_t;
    typedef acc_t accs_t[$];
    acc_t acc_q[$];
    int   tick_q[$], sv_q[$];
    always @(negedge clk) begin
        if (avm.chipselect) acc_q.push_back('{cyc, !avm.write_n, avm.address, avm.writedata});
        if (tick) tick_q.push_back(cyc);
        if (snap_valid) sv_q.push_back(cyc);
    end

    function automatic accs_t accs_after(input int r);
        accs_t n;
        foreach (acc_q[i]) if (acc_q[i].c > r) n.push_back(acc_q[i]);
        return n;
    endfunction

    function automatic int n_after(input int q[$], input int r, output int first);
        n_after = 0;
        first = -1;
        foreach (q[i]) if (q[i] > r) begin
            if (first < 0) first = q[i];
            n_after++;
        end
    endfunction

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] p, input logic c, output int s);
        cfg_period = p;
        cfg_continuous = c;
        cfg_start = 1'b1;
        s = cyc;
        next();
        cfg_start = 1'b0;
    endtask

    task automatic stop_and_settle();
        cfg_stop = 1'b1;
        next();
        cfg_stop = 1'b0;
        repeat (4) next();
    endtask

    task automatic test_reset();
        repeat (3) next();
        total++;
        if ({busy, running, tick, tick_count, snap_valid, snap_value} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {busy, running, tick, tick_count, snap_valid, snap_value});
        end
        total++;
        if ({avm.chipselect, avm.write_n, avm.address, avm.writedata} !== {1'b0, 1'b1, 3'd0, 16'h0}) begin
            bad++;
            $display("FAIL reset_bus: got cs=%b wn=%b a=%0d d=%h want cs=0 wn=1 a=0 d=0",
                     avm.chipselect, avm.write_n, avm.address, avm.writedata);
        end
        reset_n = 1'b1;
        next();
    endtask

    task automatic test_continuous();
        int s, k, t;
        accs_t n;
        logic [19:0] ew [5];
        ew = '{{1'b1, 3'd1, 16'h0008}, {1'b1, 3'd2, 16'h0009}, {1'b1, 3'd3, 16'h0000},
               {1'b1, 3'd0, 16'h0000}, {1'b1, 3'd1, 16'h0007}};
        start(32'd9, 1'b1, s);
        repeat (4) next();
        total++;
        if (running !== 1'b0) begin bad++; $display("FAIL cont_running_early: got %b want 0", running); end
        next();
        total++;
        if ({running, busy} !== 2'b10) begin bad++; $display("FAIL cont_running: got run=%b busy=%b want 1 0", running, busy); end
        n = accs_after(s);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= n.size() || {n[i].w, n[i].a, n[i].d} !== ew[i] || n[i].c != s + 1 + i) begin
                bad++;
                $display("FAIL cont_write%0d: got %h@%0d want %h@%0d", i, {n[i].w, n[i].a, n[i].d}, n[i].c, ew[i], s + 1 + i);
            end
        end
        k = 0;
        for (int i = 0; i < 260 && k < 20; i++) begin
            next();
            if (tick) begin
                k++;
                exp_ticks++;
                total++;
                if (cyc != s + 7 + 10 * k || tick_count !== TW'(exp_ticks)) begin
                    bad++;
                    $display("FAIL cont_tick%0d: got cyc=%0d cnt=%0d want cyc=%0d cnt=%0d", k, cyc, tick_count, s + 7 + 10 * k, TW'(exp_ticks));
                end
            end
        end
        total++;
        if (k != 20) begin bad++; $display("FAIL cont_tick_timeout: got %0d ticks want 20", k); end
        t = cyc;
        cfg_stop = 1'b1;
        next();
        cfg_stop = 1'b0;
        repeat (2) next();
        total++;
        if ({running, busy} !== 2'b00) begin bad++; $display("FAIL cont_stop_idle: got run=%b busy=%b want 0 0", running, busy); end
        n = accs_after(t);
        total++;
        if (n.size() != 1 || {n[0].w, n[0].a, n[0].d} !== {1'b1, 3'd1, 16'h0008} || n[0].c != t + 2) begin
            bad++;
            $display("FAIL cont_halt_write: got n=%0d %h@%0d want n=1 %h@%0d", n.size(), {n[0].w, n[0].a, n[0].d}, n[0].c, {1'b1, 3'd1, 16'h0008}, t + 2);
        end
    endtask

    task automatic test_one_shot();
        int s, nt, ft;
        accs_t n;
        start(32'd4, 1'b0, s);
        repeat (30) next();
        exp_ticks++;
        nt = n_after(tick_q, s, ft);
        total++;
        if (nt != 1 || ft != s + 12) begin bad++; $display("FAIL oneshot_tick: got n=%0d at %0d want n=1 at %0d", nt, ft, s + 12); end
        total++;
        if (tick_count !== TW'(exp_ticks)) begin bad++; $display("FAIL oneshot_count: got %0d want %0d", tick_count, TW'(exp_ticks)); end
        total++;
        if ({running, busy} !== 2'b00) begin bad++; $display("FAIL oneshot_idle: got run=%b busy=%b want 0 0", running, busy); end
        n = accs_after(s);
        total++;
        if (n.size() != 6 || {n[4].w, n[4].a, n[4].d} !== {1'b1, 3'd1, 16'h0005} || {n[5].w, n[5].a, n[5].d} !== {1'b1, 3'd0, 16'h0000}) begin
            bad++;
            $display("FAIL oneshot_writes: got n=%0d ctrl=%h last=%h want n=6 ctrl=%h last=%h", n.size(),
                     {n[4].w, n[4].a, n[4].d}, {n[5].w, n[5].a, n[5].d}, {1'b1, 3'd1, 16'h0005}, {1'b1, 3'd0, 16'h0000});
        end
    endtask

    task automatic test_snapshot();
        int s, r, w, nv, fv;
        logic [31:0] p, exp;
        accs_t n;
        for (int it = 0; it < 3; it++) begin
            p = $urandom_range(32'h0002_0000, 32'h0007_ffff);
            w = $urandom_range(1, 40);
            start(p, 1'b1, s);
            repeat (5 + w) next();
            r = cyc;
            exp = p - 32'(r - s - 6) - 32'd2;
            snap_req = 1'b1;
            next();
            snap_req = 1'b0;
            repeat (8) next();
            n = accs_after(r);
            total++;
            if (n.size() != 3 || {n[0].w, n[0].a, n[0].d} !== {1'b1, 3'd4, 16'h0} || n[0].c != r + 2 ||
                {n[1].w, n[1].a} !== {1'b0, 3'd4} || n[1].c != r + 3 || {n[2].w, n[2].a} !== {1'b0, 3'd5} || n[2].c != r + 4) begin
                bad++;
                $display("FAIL snap_seq%0d: got n=%0d %h@%0d %h@%0d %h@%0d want wr4@%0d rd4@%0d rd5@%0d", it, n.size(),
                         {n[0].w, n[0].a}, n[0].c, {n[1].w, n[1].a}, n[1].c, {n[2].w, n[2].a}, n[2].c, r + 2, r + 3, r + 4);
            end
            nv = n_after(sv_q, r, fv);
            total++;
            if (nv != 1 || fv != r + 6) begin bad++; $display("FAIL snap_valid%0d: got n=%0d at %0d want n=1 at %0d", it, nv, fv, r + 6); end
            total++;
            if (snap_value !== exp) begin bad++; $display("FAIL snap_value%0d: got %h want %h", it, snap_value, exp); end
            stop_and_settle();
            total++;
            if ({running, busy} !== 2'b00) begin bad++; $display("FAIL snap_stop%0d: got run=%b busy=%b want 0 0", it, running, busy); end
        end
    endtask

    task automatic test_irq_during_snap();
        int s, r, nt, ft, nv, fv;
        logic [31:0] p;
        accs_t n;
        p = $urandom_range(20, 60);
        start(p, 1'b1, s);
        repeat (p + 3) next();
        r = cyc;
        snap_req = 1'b1;
        next();
        snap_req = 1'b0;
        repeat (9) next();
        exp_ticks++;
        nv = n_after(sv_q, r, fv);
        nt = n_after(tick_q, r, ft);
        total++;
        if (nv != 1 || fv != r + 6 || nt != 1 || ft != r + 7) begin
            bad++;
            $display("FAIL irqsnap_order: got valid n=%0d@%0d tick n=%0d@%0d want 1@%0d 1@%0d", nv, fv, nt, ft, r + 6, r + 7);
        end
        n = accs_after(r);
        total++;
        if (n.size() != 4 || n[2].a != 3'd5 || {n[3].w, n[3].a, n[3].d} !== {1'b1, 3'd0, 16'h0} || n[3].c != r + 7) begin
            bad++;
            $display("FAIL irqsnap_bus: got n=%0d last=%h@%0d want n=4 last=%h@%0d", n.size(), {n[3].w, n[3].a, n[3].d}, n[3].c, {1'b1, 3'd0, 16'h0}, r + 7);
        end
        total++;
        if (tick_count !== TW'(exp_ticks) || snap_value !== 32'd0) begin
            bad++;
            $display("FAIL irqsnap_count: got cnt=%0d snap=%h want cnt=%0d snap=0", tick_count, snap_value, TW'(exp_ticks));
        end
        stop_and_settle();
    endtask

    task automatic test_stop_and_snap();
        int s, r, nv, fv;
        accs_t n;
        start(32'd1000, 1'b1, s);
        repeat (9) next();
        r = cyc;
        cfg_stop = 1'b1;
        snap_req = 1'b1;
        next();
        cfg_stop = 1'b0;
        snap_req = 1'b0;
        repeat (2) next();
        total++;
        if ({running, busy} !== 2'b00) begin bad++; $display("FAIL stopsnap_idle: got run=%b busy=%b want 0 0", running, busy); end
        repeat (10) next();
        n = accs_after(r);
        total++;
        if (n.size() != 1 || {n[0].w, n[0].a, n[0].d} !== {1'b1, 3'd1, 16'h0008} || n[0].c != r + 2) begin
            bad++;
            $display("FAIL stopsnap_bus: got n=%0d %h@%0d want n=1 %h@%0d", n.size(), {n[0].w, n[0].a, n[0].d}, n[0].c, {1'b1, 3'd1, 16'h0008}, r + 2);
        end
        nv = n_after(sv_q, r, fv);
        total++;
        if (nv != 0) begin bad++; $display("FAIL stopsnap_valid: got %0d pulses want 0", nv); end
    endtask

    task automatic test_reset_mid_sequence();
        int s;
        accs_t n;
        logic [19:0] ew [5];
        ew = '{{1'b1, 3'd1, 16'h0008}, {1'b1, 3'd2, 16'h0000}, {1'b1, 3'd3, 16'h0001},
               {1'b1, 3'd0, 16'h0000}, {1'b1, 3'd1, 16'h0007}};
        start($urandom, 1'b1, s);
        repeat (2) next();
        reset_n = 1'b0;
        #1;
        total++;
        if ({avm.chipselect, avm.write_n, avm.address, avm.writedata, busy, running} !== {1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_async: got cs=%b wn=%b a=%0d d=%h busy=%b run=%b want 0 1 0 0 0 0",
                     avm.chipselect, avm.write_n, avm.address, avm.writedata, busy, running);
        end
        next();
        reset_n = 1'b1;
        next();
        exp_ticks = 0;
        total++;
        if (tick_count !== TW'(exp_ticks)) begin bad++; $display("FAIL reset_count: got %0d want 0", tick_count); end
        start(32'h0001_0000, 1'b1, s);
        repeat (5) next();
        n = accs_after(s);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= n.size() || {n[i].w, n[i].a, n[i].d} !== ew[i] || n[i].c != s + 1 + i) begin
                bad++;
                $display("FAIL restart_write%0d: got %h@%0d want %h@%0d", i, {n[i].w, n[i].a, n[i].d}, n[i].c, ew[i], s + 1 + i);
            end
        end
        total++;
        if (running !== 1'b1) begin bad++; $display("FAIL restart_running: got %b want 1", running); end
        stop_and_settle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_continuous();
        test_one_shot();
        test_snapshot();
        test_irq_during_snap();
        test_stop_and_snap();
        test_reset_mid_sequence();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lt24_timer_driver.md
Name: lt24_timer_driver

Overview:
- Avalon-MM master that drives the interval-timer slave over its s1 port: 3-bit word address, 16-bit data, registered readdata with 1-cycle latency, active-high irq.
- Programs the period, starts and stops the timer, services and clears the timeout IRQ, and captures 32-bit counter snapshots.
- Gives the LT24 painter logic a hardware tick source with no Nios involvement.
- Sits between the painter control FSM and the timer slave.

Parameters:
- TICK_CNT_W, 16, width of the tick_count output.
- ADDR_W, 3, timer address width; fixed, must equal 3.
- DATA_W, 16, timer data width; fixed, must equal 16.

Ports:
- clk  in  1  system clock, shared with the timer.
- reset_n  in  1  reset.
- cfg_start  in  1  pulse; program the timer and start it.
- cfg_period  in  32  timer load value; the resulting period is cfg_period+1 clocks.
- cfg_continuous  in  1  1 = periodic, 0 = one-shot.
- cfg_stop  in  1  pulse; stop the timer.
- snap_req  in  1  pulse; capture the current counter value.
- busy  out  1  high in every state except IDLE and RUN.
- running  out  1  high while the timer is started.
- tick  out  1  1-cycle pulse per serviced timeout.
- tick_count  out  TICK_CNT_W  count of serviced timeouts; wraps.
- snap_valid  out  1  1-cycle pulse when snap_value updates.
- snap_value  out  32  last captured counter value.
- avm_address  out  3  timer register address.
- avm_chipselect  out  1  bus access strobe.
- avm_write_n  out  1  0 = write, 1 = read.
- avm_writedata  out  16  write data.
- avm_readdata  in  16  timer read data, valid 1 cycle after the address.
- avm_irq  in  1  timer interrupt.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. Reset values: all outputs 0 except avm_write_n=1. FSM in IDLE, pending flags cleared.
- Bus protocol:
  - At most one access per cycle; all bus outputs are registered.
  - Write: chipselect=1, write_n=0 for exactly 1 cycle.
  - Read: chipselect=1, write_n=1 for 1 cycle; data is sampled on the following cycle.
  - When no access is in progress: chipselect=0, write_n=1, address=0, writedata=0.
- FSM states: IDLE, W_STOP, W_PERL, W_PERH, W_CLR, W_CTRL, RUN, IRQ_CLR, S_WR, S_RDL, S_RDH, S_CAP, HALT.
- Start sequence:
  - IDLE + cfg_start: latch cfg_period and cfg_continuous, then perform 5 writes, one per cycle.
  - W_STOP: addr1 = 0x0008.
  - W_PERL: addr2 = period[15:0].
  - W_PERH: addr3 = period[31:16].
  - W_CLR: addr0 = 0x0000.
  - W_CTRL: addr1 = 0x0005 | (continuous<<1).
  - Then RUN; running goes 1 on entry to RUN.
- RUN priority is avm_irq > stop_pend > snap_pend.
- IRQ service:
  - IRQ_CLR writes addr0 = 0x0000; tick pulses in the same cycle and tick_count increments, wrapping from all-ones to 0.
  - Next state is RUN if continuous, else IDLE with running=0 and no stop write (the timer has already self-stopped).
- Stop: HALT writes addr1 = 0x0008, then IDLE with running=0.
- Snapshot (one sequence):
  - S_WR: write addr4 = 0x0000 (latches the counter).
  - S_RDL: read addr4.
  - S_RDH: read addr5; capture readdata into snap_value[15:0].
  - S_CAP: no access; capture readdata into snap_value[31:16]; snap_valid=1.
  - Return to RUN.
- Pending flags:
  - cfg_stop and snap_req set stop_pend / snap_pend in any state except IDLE.
  - Each flag clears when its sequence starts.
  - Both flags clear on entry to IDLE.
  - In IDLE, cfg_stop and snap_req are ignored.
- cfg_start is ignored outside IDLE.
- A timeout that occurs during a sequence stays latched in the slave; it is serviced on the next RUN cycle and is never lost.
- Simultaneous cfg_start and cfg_stop in IDLE: start wins; stop is ignored.
- Reset mid-sequence: the FSM returns to IDLE immediately. The timer keeps its state; the next cfg_start re-programs it fully, beginning with the stop write.

Decomposition:
- Shared package lt24_timer_pkg:
  - Register address constants: ADDR_STATUS=0, ADDR_CONTROL=1, ADDR_PERIODL=2, ADDR_PERIODH=3, ADDR_SNAPL=4, ADDR_SNAPH=5.
  - Control bit constants: ITO=0, CONT=1, START=2, STOP=3.
  - FSM state enum.
- One sub-module, lt24_avm_access: registers the bus outputs from a {valid, write, addr, data} request; used for all accesses.

Test Plan:
- Start with cfg_period=9, cfg_continuous=1 against the timer model. Required:
  - Writes in order: (1,0x0008) (2,0x0009) (3,0x0000) (0,0x0000) (1,0x0007).
  - running=1 on the 6th cycle after cfg_start.
  - tick every 10 cycles; tick_count=5 after 5 periods.
- One-shot with cfg_period=4: exactly 1 tick, tick_count=1, then IDLE with running=0, busy=0, and no control write after the addr0 clear.
- snap_req with the counter running: sequence write4, read4, read5. snap_value equals the model's internal_counter at the write4 edge; snap_valid pulses once, 4 cycles after the sequence starts.
- irq asserted during S_RDL: the snapshot completes, then IRQ_CLR runs immediately; tick_count increments by exactly 1.
- cfg_stop and snap_req pulsed in the same RUN cycle: HALT (1,0x0008) executes, then IDLE; snap_pend is cleared and no snapshot accesses occur.
- reset_n low during W_PERH: outputs return to reset values asynchronously. A following cfg_start with cfg_period=0x0001_0000 writes (2,0x0000) then (3,0x0001).
